gray_updown_counter: RTL and testbench

//  Synchronous WIDTH-bit up/down counter whose primary output is Gray code.
//  It sits directly upstream of the Gray-to-binary converter stage and feeds it.
//  A registered binary copy is provided alongside, so the bench can check the converter against it.
//  A sticky integrity flag reports any output step that changed more than one bit.

---
 rtl/gray_updown_counter_pkg.sv | 18 +
 rtl/gray_to_bin_comb.sv | 15 +
 rtl/gray_updown_counter.sv | 72 +++++++
 tb/tb_gray_updown_counter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/gray_updown_counter_pkg.sv
// Shared constants and helpers for the Gray up/down counter and its converter stage.
package gray_updown_counter_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  // Widest count the helper functions handle; callers zero-extend to this width.
  localparam int GRAY_W_MAX     = 32;

  // Binary to reflected Gray code.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic popcount_is_one(input logic [GRAY_W_MAX-1:0] v);
    return (v != '0) && ((v & (v - GRAY_W_MAX'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_to_bin_comb.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at or above its position (prefix XOR from the MSB down).
module gray_to_bin_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each output bit reduces its own slice, so there is no ripple through bin itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_updown_counter.sv
// WIDTH-bit up/down counter with registered Gray and binary outputs,
// a wrap pulse and a sticky flag for any multi-bit Gray step.
module gray_updown_counter
  import gray_updown_counter_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc,
  output logic             err
);

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] gray_next;
  logic             tc_next;
  logic             step_err;

  gray_to_bin_comb #(.WIDTH(WIDTH)) u_load_dec (
    .gray (load_gray),
    .bin  (load_bin)
  );

  // Next count: load beats a count step, otherwise hold; wrap flagged on the step that crosses zero.
  always_comb begin
    b_next  = bin_out;
    tc_next = 1'b0;
    if (load) begin
      b_next = load_bin;
    end else if (en) begin
      if (up_dn) begin
        b_next  = bin_out + WIDTH'(1);
        tc_next = (bin_out == '1);
      end else begin
        b_next  = bin_out - WIDTH'(1);
        tc_next = (bin_out == '0);
      end
    end
  end

  // Gray is derived from the next binary count so both outputs register the same value;
  // only real count steps are checked, loads may jump arbitrarily.
  always_comb begin
    gray_next = WIDTH'(bin2gray(GRAY_W_MAX'(b_next)));
    step_err  = en && !load && !popcount_is_one(GRAY_W_MAX'(gray_next ^ gray_out));
  end

  // Count, output and sticky-error registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_out  <= '0;
      gray_out <= '0;
      tc       <= 1'b0;
      err      <= 1'b0;
    end else begin
      bin_out  <= b_next;
      gray_out <= gray_next;
      tc       <= tc_next;
      if (step_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed self-checking bench for gray_updown_counter at WIDTH=4.
module tb_gray_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_gray;
  logic [W-1:0] gray_out;
  logic [W-1:0] bin_out;
  logic         tc;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  gray_updown_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_gray (load_gray),
    .gray_out  (gray_out),
    .bin_out   (bin_out),
    .tc        (tc),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] b, input logic t);
    chk({tag, ".gray"}, 32'(gray_out), 32'(g));
    chk({tag, ".bin"},  32'(bin_out),  32'(b));
    chk({tag, ".tc"},   32'(tc),       32'(t));
    chk({tag, ".err"},  32'(err),      32'd0);
  endtask

  logic [3:0] up_seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                              4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  // Alternating-direction walk from bin 0100: up, down, up, down, down, up.
  logic       alt_dir [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0] alt_bin [6] = '{4'b0101, 4'b0100, 4'b0101, 4'b0100, 4'b0011, 4'b0100};
  logic [3:0] alt_gry [6] = '{4'b0111, 4'b0110, 4'b0111, 4'b0110, 4'b0010, 4'b0110};

  initial begin
    // 1 reset dominates en and load
    rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_gray = 4'b1010;
    tick(); tick();
    chk_all("reset", 4'b0000, 4'b0000, 1'b0);

    // 2 full up cycle, wrap pulse on the last step only
    rst_n = 1'b1; load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("up%0d.gray", i), 32'(gray_out), 32'(up_seq[i]));
      chk($sformatf("up%0d.bin", i),  32'(bin_out),  32'((i + 1) % 16));
      chk($sformatf("up%0d.tc", i),   32'(tc),       32'(i == 15));
    end
    chk("up.err", 32'(err), 32'd0);

    // 3 down from zero wraps to all-ones
    up_dn = 1'b0;
    tick();
    chk_all("dn_wrap", 4'b1000, 4'b1111, 1'b1);
    tick();
    chk_all("dn_next", 4'b1001, 4'b1110, 1'b0);

    // 4 load, then load wins over en
    en = 1'b0; load = 1'b1; load_gray = 4'b1101;
    tick();
    chk_all("load", 4'b1101, 4'b1001, 1'b0);
    en = 1'b1; up_dn = 1'b1; load_gray = 4'b0110;
    tick();
    chk_all("load_en", 4'b0110, 4'b0100, 1'b0);

    // 5 hold, then direction reversals
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("hold%0d", i), 4'b0110, 4'b0100, 1'b0);
    end
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up_dn = alt_dir[i];
      tick();
      chk_all($sformatf("alt%0d", i), alt_gry[i], alt_bin[i], 1'b0);
    end

    // wrap pulse also on a reversal at zero, cleared by a following load
    en = 1'b0; load = 1'b1; load_gray = 4'b0001;
    tick();
    chk_all("ld1", 4'b0001, 4'b0001, 1'b0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    chk_all("rev_to0", 4'b0000, 4'b0000, 1'b0);
    tick();
    chk_all("rev_wrap", 4'b1000, 4'b1111, 1'b1);
    up_dn = 1'b1;
    tick();
    chk_all("rev_back", 4'b0000, 4'b0000, 1'b1);
    en = 1'b0; load = 1'b1; load_gray = 4'b0111;
    tick();
    chk_all("ld5", 4'b0111, 4'b0101, 1'b0);

    // 6 mid-count reset at bin 0111
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    chk_all("mc6", 4'b0101, 4'b0110, 1'b0);
    tick();
    chk_all("mc7", 4'b0100, 4'b0111, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_all("mc_rst", 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_all("mc_resume", 4'b0001, 4'b0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
